// File: rtl/board_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | board_pkg: LED mode encodings, reset-FSM states, LED mode decode helper.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package board_pkg;

  localparam logic [1:0] LED_DIRECT = 2'b00;
  localparam logic [1:0] LED_PWM    = 2'b01;
  localparam logic [1:0] LED_BLINK  = 2'b10;
  localparam logic [1:0] LED_OFF    = 2'b11;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_COUNT = 2'd1,
    ST_RUN   = 2'd2
  } rst_state_e;

  function automatic logic led_next(input logic [1:0] mode, input logic req,
                                    input logic pwm_on, input logic blink_on);
    logic v;
    case (mode)
      LED_DIRECT: v = req;
      LED_PWM:    v = req & pwm_on;
      LED_BLINK:  v = req & blink_on;
      default:    v = 1'b0;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | btn_debounce: one button channel - synchroniser, polarity, debounce.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module btn_debounce
  import board_pkg::*;
#(
  parameter int DEB_CYCLES     = 65536,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int             CW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          pressed_raw;
  logic          sync1_q, sync2_q;
  logic          level_q, press_q;
  logic [CW-1:0] cnt_q;

  // Polarity is folded in ahead of the flops so a cleared synchroniser means
  // "released"; otherwise an active-low button would look pressed out of reset.
  assign pressed_raw = BTN_ACTIVE_LOW ? ~btn_raw_i : btn_raw_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pressed_raw;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        press_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/board_frontend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | board_frontend: button debounce, core reset sequencer and LED PWM/blink.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module board_frontend
  import board_pkg::*;
#(
  parameter int NBTN           = 1,
  parameter int NLED           = 8,
  parameter int DEB_CYCLES     = 65536,
  parameter int RST_CYCLES     = 16,
  parameter bit BTN_ACTIVE_LOW = 1'b1,
  parameter int PWM_BITS       = 8,
  parameter int BLINK_BITS     = 23
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pll_locked,
  input  logic [NBTN-1:0]     btn_raw,
  input  logic [NLED-1:0]     leds_in,
  input  logic [2*NLED-1:0]   led_mode,
  input  logic [PWM_BITS-1:0] led_duty,
  output logic [NBTN-1:0]     btn_level,
  output logic [NBTN-1:0]     btn_press,
  output logic                sys_reset,
  output logic                sys_ready,
  output logic [NLED-1:0]     led_out
);

  localparam int              RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0]  RST_LAST = RCW'(RST_CYCLES - 1);

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES     (DEB_CYCLES),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_deb (
      .clk       (clk),
      .reset     (reset),
      .btn_raw_i (btn_raw[g]),
      .level_o   (btn_level[g]),
      .press_o   (btn_press[g])
    );
  end

  rst_state_e     state_q;
  logic [RCW-1:0] rst_cnt_q;
  logic           pll_s1_q, pll_s2_q;
  logic           sys_reset_q;
  logic           leave;
  logic           run_d;

  assign leave = ~pll_s2_q | btn_level[0];

  // Next-cycle "core running" flag; shared by the FSM and the LED gate so the
  // LEDs go dark on exactly the edge sys_reset rises.
  always_comb begin
    run_d = 1'b0;
    case (state_q)
      ST_COUNT: run_d = ~leave & (rst_cnt_q == RST_LAST);
      ST_RUN:   run_d = ~leave;
      default:  run_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pll_s1_q    <= 1'b0;
      pll_s2_q    <= 1'b0;
      state_q     <= ST_HOLD;
      rst_cnt_q   <= '0;
      sys_reset_q <= 1'b1;
    end else begin
      pll_s1_q    <= pll_locked;
      pll_s2_q    <= pll_s1_q;
      sys_reset_q <= ~run_d;
      case (state_q)
        ST_HOLD: begin
          rst_cnt_q <= '0;
          if (pll_s2_q && !btn_level[0]) state_q <= ST_COUNT;
        end
        ST_COUNT: begin
          if (leave) begin
            state_q   <= ST_HOLD;
            rst_cnt_q <= '0;
          end else if (rst_cnt_q == RST_LAST) begin
            state_q   <= ST_RUN;
            rst_cnt_q <= '0;
          end else begin
            rst_cnt_q <= rst_cnt_q + RCW'(1);
          end
        end
        ST_RUN: begin
          rst_cnt_q <= '0;
          if (leave) state_q <= ST_HOLD;
        end
        default: begin
          state_q   <= ST_HOLD;
          rst_cnt_q <= '0;
        end
      endcase
    end
  end

  assign sys_reset = sys_reset_q;
  assign sys_ready = ~sys_reset_q;

  logic [PWM_BITS-1:0]   pwm_cnt_q;
  logic [BLINK_BITS-1:0] blink_cnt_q;
  logic [NLED-1:0]       led_d, led_out_q;
  logic                  pwm_on, blink_on;

  assign pwm_on   = (pwm_cnt_q < led_duty);
  assign blink_on = blink_cnt_q[BLINK_BITS-1];

  always_comb begin
    led_d = '0;
    for (int i = 0; i < NLED; i++) begin
      led_d[i] = run_d & led_next(led_mode[2*i +: 2], leds_in[i], pwm_on, blink_on);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      led_out_q   <= '0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_q + PWM_BITS'(1);
      blink_cnt_q <= blink_cnt_q + BLINK_BITS'(1);
      led_out_q   <= led_d;
    end
  end

  assign led_out = led_out_q;

endmodule
`default_nettype wire

// File: tb/tb_board_frontend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_board_frontend: directed self-checking bench for board_frontend.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_board_frontend;

  localparam int NBTN = 2;
  localparam int NLED = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              pll_locked;
  logic [NBTN-1:0]   btn_raw;
  logic [NLED-1:0]   leds_in;
  logic [2*NLED-1:0] led_mode;
  logic [3:0]        led_duty;
  logic [NBTN-1:0]   btn_level;
  logic [NBTN-1:0]   btn_press;
  logic              sys_reset;
  logic              sys_ready;
  logic [NLED-1:0]   led_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference copy of the free-running PWM/blink counter (both 4 bits here).
  logic [3:0] m_cnt;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) m_cnt <= 4'd0;
    else       m_cnt <= m_cnt + 4'd1;
  end

  board_frontend #(
    .NBTN           (NBTN),
    .NLED           (NLED),
    .DEB_CYCLES     (4),
    .RST_CYCLES     (16),
    .BTN_ACTIVE_LOW (1'b1),
    .PWM_BITS       (4),
    .BLINK_BITS     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
    .btn_raw    (btn_raw),
    .leds_in    (leds_in),
    .led_mode   (led_mode),
    .led_duty   (led_duty),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .sys_reset  (sys_reset),
    .sys_ready  (sys_ready),
    .led_out    (led_out)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; pll_locked = 1'b0; btn_raw = 2'b11;
    leds_in = 4'hF; led_mode = 8'h00; led_duty = 4'd0;
    tick(); tick();
    n_checks++; if (sys_reset !== 1'b1) begin n_fail++; $display("FAIL reset_sys_reset got %b want 1", sys_reset); end
    n_checks++; if (sys_ready !== 1'b0) begin n_fail++; $display("FAIL reset_sys_ready got %b want 0", sys_ready); end
    n_checks++; if (btn_level !== 2'b00) begin n_fail++; $display("FAIL reset_btn_level got %b want 00", btn_level); end
    n_checks++; if (btn_press !== 2'b00) begin n_fail++; $display("FAIL reset_btn_press got %b want 00", btn_press); end
    n_checks++; if (led_out !== 4'h0) begin n_fail++; $display("FAIL reset_led_out got %h want 0", led_out); end
    reset = 1'b0;
  endtask

  // 2 synchroniser edges, 1 HOLD->COUNT edge, then 16 cycles in COUNT.
  task automatic test_startup();
    logic exp_rst;
    pll_locked = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick();
      exp_rst = (k < 19);
      n_checks++;
      if (sys_reset !== exp_rst || sys_ready !== ~exp_rst) begin
        n_fail++; $display("FAIL startup_k%0d sys_reset/ready got %b%b want %b%b", k, sys_reset, sys_ready, exp_rst, ~exp_rst);
      end
      n_checks++;
      if (led_out !== (exp_rst ? 4'h0 : 4'hF)) begin
        n_fail++; $display("FAIL startup_led_k%0d got %h want %h", k, led_out, exp_rst ? 4'h0 : 4'hF);
      end
    end
  endtask

  task automatic test_led_modes();
    logic [3:0] prev;
    logic [3:0] exp;
    leds_in  = 4'hF;
    led_mode = 8'b01_11_10_00;  // ch3 PWM, ch2 OFF, ch1 BLINK, ch0 DIRECT
    led_duty = 4'd5;
    for (int k = 0; k < 32; k++) begin
      tick();
      prev = m_cnt - 4'd1;
      exp  = {(prev < 4'd5), 1'b0, prev[3], 1'b1};
      n_checks++;
      if (led_out !== exp) begin
        n_fail++; $display("FAIL led_modes_k%0d got %b want %b", k, led_out, exp);
      end
    end
  endtask

  task automatic test_pwm();
    logic [3:0] duties [3];
    int hi;
    duties[0] = 4'd5; duties[1] = 4'd0; duties[2] = 4'd15;
    leds_in  = 4'hF;
    led_mode = 8'b01_01_01_01;
    for (int d = 0; d < 3; d++) begin
      led_duty = duties[d];
      tick();
      hi = 0;
      for (int k = 0; k < 16; k++) begin
        tick();
        if (led_out[0]) hi++;
      end
      n_checks++;
      if (hi != int'(duties[d])) begin
        n_fail++; $display("FAIL pwm_duty%0d high_cycles got %0d want %0d", duties[d], hi, duties[d]);
      end
    end
  endtask

  task automatic test_sysreset_gate();
    logic exp_rst;
    leds_in  = 4'hF;
    led_mode = 8'h00;
    tick();
    n_checks++; if (led_out !== 4'hF) begin n_fail++; $display("FAIL gate_run_led got %h want F", led_out); end
    pll_locked = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_rst = (k >= 3);
      n_checks++;
      if (sys_reset !== exp_rst) begin
        n_fail++; $display("FAIL gate_sys_reset_k%0d got %b want %b", k, sys_reset, exp_rst);
      end
      n_checks++;
      if (led_out !== (exp_rst ? 4'h0 : 4'hF)) begin
        n_fail++; $display("FAIL gate_led_k%0d got %h want %h", k, led_out, exp_rst ? 4'h0 : 4'hF);
      end
    end
  endtask

  task automatic test_debounce_short();
    btn_raw[0] = 1'b0;
    tick(); tick(); tick();
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if (btn_level[0] !== 1'b0 || btn_press[0] !== 1'b0) begin
        n_fail++; $display("FAIL deb_short_k%0d level/press got %b%b want 00", k, btn_level[0], btn_press[0]);
      end
    end
  endtask

  task automatic test_debounce_hold();
    btn_raw[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_checks++;
      if (btn_level[0] !== (k >= 6) || btn_press[0] !== (k == 6)) begin
        n_fail++; $display("FAIL deb_hold_k%0d level/press got %b%b want %b%b", k, btn_level[0], btn_press[0], k >= 6, k == 6);
      end
    end
    n_checks++; if (sys_reset !== 1'b1) begin n_fail++; $display("FAIL deb_hold_sys_reset got %b want 1", sys_reset); end
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_checks++;
      if (btn_level[0] !== (k < 6) || btn_press[0] !== 1'b0) begin
        n_fail++; $display("FAIL deb_release_k%0d level/press got %b%b want %b0", k, btn_level[0], btn_press[0], k < 6);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_lvl;
    logic [1:0] exp_prs;
    pll_locked = 1'b1;
    btn_raw    = 2'b01;  // channel 1 pressed, channel 0 released
    for (int k = 0; k < 5; k++) tick();
    n_checks++;
    if (sys_reset !== 1'b1 || btn_level !== 2'b00) begin
      n_fail++; $display("FAIL mid_pre got sys_reset=%b level=%b want 1 00", sys_reset, btn_level);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({sys_reset, sys_ready, btn_level, btn_press, led_out} !== {1'b1, 1'b0, 2'b00, 2'b00, 4'h0}) begin
      n_fail++; $display("FAIL mid_reset got %b%b %b %b %h want 10 00 00 0", sys_reset, sys_ready, btn_level, btn_press, led_out);
    end
    reset = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      exp_lvl = (k >= 6) ? 2'b10 : 2'b00;
      exp_prs = (k == 6) ? 2'b10 : 2'b00;
      n_checks++;
      if (sys_reset !== (k < 19)) begin
        n_fail++; $display("FAIL mid_restart_k%0d sys_reset got %b want %b", k, sys_reset, k < 19);
      end
      n_checks++;
      if (btn_level !== exp_lvl || btn_press !== exp_prs) begin
        n_fail++; $display("FAIL mid_btn_k%0d level/press got %b %b want %b %b", k, btn_level, btn_press, exp_lvl, exp_prs);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_startup();
    test_led_modes();
    test_pwm();
    test_sysreset_gate();
    test_debounce_short();
    test_debounce_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/board_frontend.md
BOARD_FRONTEND -- requirements
Module: board_frontend

Interface
REQ-001 Parameter NBTN, default 1: number of push-button channels, 1..8.
REQ-002 Parameter NLED, default 8: number of LED channels, 1..16.
REQ-003 Parameter DEB_CYCLES, default 65536: stable cycles required to accept a button change, >=2.
REQ-004 Parameter RST_CYCLES, default 16: cycles sys_reset stays high after release conditions clear, >=1.
REQ-005 Parameter BTN_ACTIVE_LOW, default 1: 1 means a raw button reads 0 when pressed.
REQ-006 Parameter PWM_BITS, default 8: width of the PWM counter and duty; BLINK_BITS, default 23: blink prescaler width.
REQ-007 clk  in  1  single system clock; all logic is clocked on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 pll_locked  in  1  PLL lock indicator; asynchronous to clk and passed through a 2-flop synchroniser.
REQ-010 btn_raw  in  NBTN  raw button pins; asynchronous.
REQ-011 leds_in  in  NLED  LED request bits from the core.
REQ-012 led_mode  in  2*NLED  per-channel mode; channel i uses bits [2i+1:2i].
REQ-013 led_duty  in  PWM_BITS  shared PWM duty.
REQ-014 btn_level  out  NBTN  debounced level, 1 = pressed.
REQ-015 btn_press  out  NBTN  one-cycle pulse on each debounced press.
REQ-016 sys_reset  out  1  registered active-high reset for the core.
REQ-017 sys_ready  out  1  equals ~sys_reset.
REQ-018 led_out  out  NLED  registered LED drive, 1 = lit.

Function
REQ-019 Each btn_raw bit passes through a 2-flop synchroniser, then polarity normalisation per BTN_ACTIVE_LOW.
REQ-020 Debounce: the per-channel counter increments while the synchronised value differs from btn_level and clears whenever it matches.
REQ-021 When the debounce counter reaches DEB_CYCLES-1, btn_level takes the new value on the next edge and the counter clears.
REQ-022 btn_press pulses high for exactly one cycle, coincident with btn_level going 0->1; a 1->0 transition produces no pulse.
REQ-023 The reset FSM has three states:
  - HOLD: sys_reset=1.
  - COUNT: sys_reset=1, counts RST_CYCLES cycles.
  - RUN: sys_reset=0.
REQ-024 HOLD->COUNT when the synchronised pll_locked=1 and btn_level[0]=0.
REQ-025 COUNT->RUN after RST_CYCLES cycles in COUNT; sys_reset falls on the cycle the FSM enters RUN.
REQ-026 From COUNT or RUN, the FSM goes to HOLD on the next edge if pll_locked=0 or btn_level[0]=1; the counter clears.
REQ-027 The PWM counter is a free-running PWM_BITS-bit counter that wraps 2^PWM_BITS-1 -> 0; pwm_on = (counter < led_duty).
REQ-028 With this comparison, duty 0 never lights and duty 2^PWM_BITS-1 lights 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
REQ-029 Blink: a free-running BLINK_BITS-bit prescaler; blink_on = its MSB.
REQ-030 led_out[i] next value depends on mode:
  - 00: leds_in[i].
  - 01: leds_in[i] & pwm_on.
  - 10: leds_in[i] & blink_on.
  - 11: 0.
REQ-031 led_out latency is one cycle from leds_in, led_mode and led_duty.
REQ-032 While sys_reset=1, led_out is forced to 0 and the PWM and blink counters keep running.
REQ-033 btn_level and btn_press keep operating in all FSM states.

Reset
REQ-034 reset=1 sets, on the next edge:
  - FSM to HOLD, sys_reset=1, sys_ready=0.
  - btn_level=0, btn_press=0, led_out=0.
  - all counters and synchroniser flops to 0.
REQ-035 Asserting reset mid-debounce or mid-COUNT abandons the operation; after reset releases, no press pulse is emitted unless the button is held DEB_CYCLES cycles anew.

Structure
REQ-036 Shared package board_pkg holds the LED mode encodings (LED_DIRECT, LED_PWM, LED_BLINK, LED_OFF) and the FSM state encoding (ST_HOLD, ST_COUNT, ST_RUN).
REQ-037 One sub-module, btn_debounce (synchroniser, polarity and counter for one channel), is instantiated NBTN times.

Verification
REQ-038 DEB_CYCLES=4, raw pressed for 3 cycles then released -> btn_level stays 0 and there is no btn_press.
REQ-039 DEB_CYCLES=4, raw held pressed -> btn_level=1 and a single btn_press pulse 2+4 cycles after the raw edge; on release, btn_level=0 with no pulse.
REQ-040 RST_CYCLES=16, pll_locked rises and btn released -> sys_reset falls after 2 synchroniser cycles plus 16 counting cycles; pll_locked drops in RUN -> sys_reset=1 within 3 cycles.
REQ-041 PWM_BITS=4, mode 01, leds_in=1, led_duty=5 -> led_out high 5 of every 16 cycles; led_duty=0 -> never high; led_duty=15 -> high 15 of 16 cycles.
REQ-042 Channels in modes 00/10/11 with leds_in all ones -> outputs follow 1, blink MSB and 0 respectively; all outputs 0 while sys_reset=1.
REQ-043 Assert reset during COUNT and during a debounce -> all outputs return to their reset values, and the full sequence repeats after release.
